// File: rtl/instr_fetch_decode_pkg.sv
// Shared constants, FSM encoding and the
// instruction word classifier for the fetch/decode front end.
package instr_fetch_decode_pkg;

  localparam logic [3:0] IC_HALT  = 4'h0;
  localparam logic [3:0] IC_IRMOV = 4'h1;
  localparam logic [3:0] IC_OP    = 4'h2;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_XOR = 4'h3;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_STOP
  } state_t;

  typedef enum logic [1:0] {
    K_NORM,
    K_HALT,
    K_ILL
  } kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.icode = w[31:28];
    d.ifun  = w[27:24];
    d.ra    = w[23:20];
    d.rb    = w[19:16];
    d.imm   = w[15:0];
    d.kind  = K_ILL;
    unique case (1'b1)
      (d.icode == IC_HALT):
        d.kind = K_HALT;
      (d.icode == IC_IRMOV):
        if (d.ifun == FN_ADD && d.ra == REG_NONE)
          d.kind = K_NORM;
      (d.icode == IC_OP):
        if (d.ifun <= FN_XOR && d.ra != REG_NONE &&
            d.rb != REG_NONE)
          d.kind = K_NORM;
      default: ;
    endcase
    // an illegal word keeps its raw fields but never leaks an immediate
    if (d.kind == K_ILL)
      d.imm = '0;
    return d;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_fifo.sv
// Two-entry FIFO holding decoded words between the
// instruction memory return and the decode consumer.
module fetch_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i)
        rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode front end: credit-limited
// fetch from a one-cycle memory into a 2-entry decode FIFO.
module instr_fetch_decode #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              working,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rEn,
  input  logic [DATA_W-1:0] imem_rDat,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        dec_icode,
  output logic [3:0]        dec_ifun,
  output logic [3:0]        dec_rA,
  output logic [3:0]        dec_rB,
  output logic [31:0]       dec_valC,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              halted,
  output logic              illegal
);

  import instr_fetch_decode_pkg::*;

  localparam int DW = $bits(dec_t);
  localparam int EW = ADDR_W + DW;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              infl_q;
  logic              end_q;
  logic              halted_q;
  logic              illegal_q;

  dec_t              word;
  dec_t              head;
  logic [EW-1:0]     fifo_head;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              live;
  logic              accept;
  logic              push;
  logic              term;
  logic              issue;
  logic              fin;
  logic              last;

  assign word   = decode(imem_rDat[31:0]);
  assign live   = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept = dec_valid & dec_ready;
  assign push   = infl_q & live;
  assign term   = push & (word.kind != K_NORM);
  // count the slot freed by this cycle's pop so a full stream sustains 1/cycle
  assign occ    = {1'b0, cnt} + {2'b0, infl_q} - {2'b0, accept};
  assign issue  = !reset & live & working & !end_q &
                  !term & (occ < 3'd2);
  assign fin    = end_q & !infl_q & (cnt == 2'd0);
  assign last   = accept & (cnt == 2'd1);

  fetch_skid_fifo #(
    .W (EW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({ipc_q, word}),
    .pop_i   (accept),
    .valid_o (dec_valid),
    .head_o  (fifo_head),
    .count_o (cnt)
  );

  assign head = dec_t'(fifo_head[DW-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ipc_q     <= '0;
      infl_q    <= 1'b0;
      end_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        ipc_q <= pc_q;
        if (&pc_q)
          end_q <= 1'b1;
        else
          pc_q <= pc_q + ADDR_W'(1);
      end
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (term) begin
            state_q <= S_DRAIN;
          end else if (fin) begin
            state_q  <= S_STOP;
            halted_q <= 1'b1;
          end else if (working) begin
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (last) begin
            state_q   <= S_STOP;
            halted_q  <= (head.kind == K_HALT);
            illegal_q <= (head.kind == K_ILL);
          end
        end
        S_STOP: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_rEn  = issue;
  assign imem_addr = pc_q;
  assign dec_icode = head.icode;
  assign dec_ifun  = head.ifun;
  assign dec_rA    = head.ra;
  assign dec_rB    = head.rb;
  assign dec_valC  = {16'h0, head.imm};
  assign dec_pc    = fifo_head[EW-1 -: ADDR_W];
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomised bench for instr_fetch_decode against a
// program-walk reference model of the fetch/decode rules.
module tb_instr_fetch_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic        working;
  logic [8:0]  imem_addr;
  logic        imem_rEn;
  logic [31:0] imem_rDat;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_icode;
  logic [3:0]  dec_ifun;
  logic [3:0]  dec_rA;
  logic [3:0]  dec_rB;
  logic [31:0] dec_valC;
  logic [8:0]  dec_pc;
  logic        halted;
  logic        illegal;

  always #5 clock = ~clock;

  instr_fetch_decode dut (
    .clock     (clock),
    .reset     (reset),
    .working   (working),
    .imem_addr (imem_addr),
    .imem_rEn  (imem_rEn),
    .imem_rDat (imem_rDat),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_icode (dec_icode),
    .dec_ifun  (dec_ifun),
    .dec_rA    (dec_rA),
    .dec_rB    (dec_rB),
    .dec_valC  (dec_valC),
    .dec_pc    (dec_pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  logic [31:0] mem [512];

  always @(posedge clock)
    if (imem_rEn) imem_rDat <= mem[imem_addr];

  typedef struct packed {
    logic [8:0]  pc;
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] vc;
  } ent_t;

  ent_t got_q[$];
  ent_t exp_q[$];
  int   acc_cyc[$];
  int   total = 0;
  int   bad = 0;
  bit   exp_halt;
  bit   exp_ill;
  int   stab_bad;
  int   first_v;
  int   max_addr;
  int   post_end;
  bit   timeout;

  task automatic do_reset();
    reset = 1'b1;
    working = 1'b0;
    dec_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_base();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    for (int i = 0; i < 6; i++)
      mem[i] = 32'h10F0001C + 32'h00010001 * 32'(i);
    mem[6] = 32'h20100000;
  endtask

  // walk memory from pc 0 applying the word rules directly
  task automatic build_model();
    logic [31:0] w;
    logic        legal;
    ent_t        e;
    exp_q.delete();
    exp_halt = 1'b0;
    exp_ill = 1'b0;
    for (int p = 0; p < 512; p++) begin
      w = mem[p];
      legal = (w[31:28] == 0) ||
              (w[31:28] == 1 && w[27:24] == 0 && w[23:20] == 15) ||
              (w[31:28] == 2 && w[27:24] <= 3 &&
               w[23:20] != 15 && w[19:16] != 15);
      e.pc = 9'(p);
      e.ic = w[31:28];
      e.fn = w[27:24];
      e.ra = w[23:20];
      e.rb = w[19:16];
      e.vc = legal ? {16'h0, w[15:0]} : 32'h0;
      exp_q.push_back(e);
      if (!legal) begin exp_ill = 1'b1; break; end
      if (w[31:28] == 0) begin exp_halt = 1'b1; break; end
      if (p == 511) exp_halt = 1'b1;
    end
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1, 2: random ready, 3: random ready+working
  task automatic run_prog(input int mode, input int limit);
    logic [57:0] snap;
    logic        pv;
    logic        pr;
    logic        r;
    bit          end_seen;
    ent_t        e;
    got_q.delete();
    acc_cyc.delete();
    stab_bad = 0;
    first_v = -1;
    max_addr = -1;
    post_end = 0;
    timeout = 1'b1;
    end_seen = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
    snap = '0;
    dec_ready = (mode == 0);
    @(negedge clock);
    working = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      if (pv && !pr &&
          {dec_valid, dec_icode, dec_ifun, dec_rA, dec_rB,
           dec_valC, dec_pc} !== snap)
        stab_bad++;
      if (dec_valid && first_v < 0) first_v = c;
      unique case (mode)
        0: r = 1'b1;
        1: r = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        default: r = 1'(($urandom_range(0, 1)));
      endcase
      if (mode == 3) working = ($urandom_range(0, 3) != 0);
      dec_ready = r;
      if (dec_valid && r) begin
        e.pc = dec_pc;
        e.ic = dec_icode;
        e.fn = dec_ifun;
        e.ra = dec_rA;
        e.rb = dec_rB;
        e.vc = dec_valC;
        got_q.push_back(e);
        acc_cyc.push_back(c);
      end
      pv = dec_valid;
      pr = r;
      snap = {dec_valid, dec_icode, dec_ifun, dec_rA, dec_rB,
              dec_valC, dec_pc};
      #1;
      if (imem_rEn) begin
        if (end_seen) post_end++;
        if (int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
        if (imem_addr == 9'd511) end_seen = 1'b1;
      end
      if ((halted || illegal) && !dec_valid) begin
        timeout = 1'b0;
        break;
      end
    end
    working = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    working = 1'b0;
    dec_ready = 1'b0;
    @(negedge clock);
    total++;
    if (dec_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %b want 0", dec_valid);
    end
    total++;
    if ({imem_rEn, imem_addr} !== 10'h0) begin
      bad++; $display("FAIL rst_imem: got %h want 0", {imem_rEn, imem_addr});
    end
    total++;
    if ({dec_icode, dec_ifun, dec_rA, dec_rB, dec_valC, dec_pc} !== 57'h0) begin
      bad++; $display("FAIL rst_fields: got %h want 0",
        {dec_icode, dec_ifun, dec_rA, dec_rB, dec_valC, dec_pc});
    end
    total++;
    if ({halted, illegal} !== 2'b00) begin
      bad++; $display("FAIL rst_flags: got %b want 00", {halted, illegal});
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({dec_valid, imem_rEn} !== 2'b00) begin
      bad++; $display("FAIL idle_hold: got %b want 00", {dec_valid, imem_rEn});
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_base();
    build_model();
    run_prog(0, 200);
    total++;
    if (timeout) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
    total++;
    if (first_v !== 2) begin
      bad++; $display("FAIL basic_latency: got %0d want 2", first_v);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (acc_cyc.size() < 7 || acc_cyc[6] - acc_cyc[0] != 6) begin
      bad++; $display("FAIL basic_b2b: got %0d accepts want 7 in 7 cycles", acc_cyc.size());
    end
    total++;
    if (got_q.size() < 7 || got_q[0].ic !== 4'h1 || got_q[0].rb !== 4'h0 ||
        got_q[0].vc !== 32'h1C) begin
      bad++; $display("FAIL basic_pc0: got %h want ic 1 rb 0 valC 1c",
        got_q.size() > 0 ? got_q[0] : '0);
    end
    total++;
    if (got_q.size() < 7 || got_q[6].ic !== 4'h2 || got_q[6].fn !== 4'h0 ||
        got_q[6].ra !== 4'h1 || got_q[6].rb !== 4'h0) begin
      bad++; $display("FAIL basic_pc6: got %h want ic 2 fn 0 ra 1 rb 0",
        got_q.size() > 6 ? got_q[6] : '0);
    end
    total++;
    if ({halted, illegal} !== {exp_halt, exp_ill}) begin
      bad++; $display("FAIL basic_flags: got %b want %b", {halted, illegal}, {exp_halt, exp_ill});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_base();
    build_model();
    run_prog(1, 300);
    total++;
    if (timeout) begin bad++; $display("FAIL bp_timeout: got 1 want 0"); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stab_bad != 0) begin
      bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_bad);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    load_base();
    mem[7] = 32'h21320000;
    mem[8] = 32'h32450000;
    mem[9] = 32'h10F50021;
    build_model();
    run_prog(2, 400);
    total++;
    if (timeout) begin bad++; $display("FAIL ill_timeout: got 1 want 0"); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ill_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ill_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (got_q.size() != 9 || got_q[7].fn !== 4'h1 || got_q[7].ra !== 4'h3 ||
        got_q[7].rb !== 4'h2 || got_q[8].ic !== 4'h3 || got_q[8].vc !== 32'h0) begin
      bad++; $display("FAIL ill_tail: got %0d entries want 9 ending SUB r3,r2 then icode 3",
        got_q.size());
    end
    total++;
    if ({halted, illegal} !== 2'b01) begin
      bad++; $display("FAIL ill_flags: got %b want 01", {halted, illegal});
    end
    total++;
    if (stab_bad != 0) begin
      bad++; $display("FAIL ill_stable: got %0d changes want 0", stab_bad);
    end
  endtask

  task automatic test_halt();
    do_reset();
    load_base();
    mem[3] = 32'h00000000;
    build_model();
    run_prog(2, 300);
    total++;
    if (timeout) begin bad++; $display("FAIL halt_timeout: got 1 want 0"); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL halt_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL halt_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if ({halted, illegal} !== 2'b10) begin
      bad++; $display("FAIL halt_flags: got %b want 10", {halted, illegal});
    end
    total++;
    if (max_addr >= 5) begin
      bad++; $display("FAIL halt_maxaddr: got %0d want <5", max_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    load_base();
    build_model();
    found = 1'b0;
    working = 1'b1;
    dec_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (dec_valid && dec_pc == 9'd2) begin
        found = 1'b1;
        break;
      end
    end
    dec_ready = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (!found) begin bad++; $display("FAIL rmid_reach: got 0 want 1"); end
    total++;
    if ({dec_valid, imem_rEn, imem_addr, halted, illegal} !== 13'h0) begin
      bad++; $display("FAIL rmid_ctl: got %h want 0",
        {dec_valid, imem_rEn, imem_addr, halted, illegal});
    end
    total++;
    if ({dec_icode, dec_ifun, dec_rA, dec_rB, dec_valC, dec_pc} !== 57'h0) begin
      bad++; $display("FAIL rmid_fields: got %h want 0",
        {dec_icode, dec_ifun, dec_rA, dec_rB, dec_valC, dec_pc});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_prog(2, 300);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rmid_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rmid_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_working_toggle();
    do_reset();
    load_base();
    for (int i = 7; i < 20; i++)
      mem[i] = {4'h2, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 14)),
                4'($urandom_range(0, 14)), 16'($urandom)};
    mem[20] = 32'h5F000000;
    build_model();
    run_prog(3, 600);
    total++;
    if (timeout) begin bad++; $display("FAIL wtog_timeout: got 1 want 0"); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL wtog_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL wtog_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (stab_bad != 0) begin
      bad++; $display("FAIL wtog_stable: got %0d changes want 0", stab_bad);
    end
    total++;
    if ({halted, illegal} !== {exp_halt, exp_ill}) begin
      bad++; $display("FAIL wtog_flags: got %b want %b", {halted, illegal}, {exp_halt, exp_ill});
    end
  endtask

  task automatic test_addr_end();
    do_reset();
    for (int i = 0; i < 512; i++)
      mem[i] = {8'h10, 4'hF, 4'($urandom_range(0, 15)), 16'($urandom)};
    mem[511] = 32'h10F00001;
    build_model();
    run_prog(2, 4000);
    total++;
    if (timeout) begin bad++; $display("FAIL end_timeout: got 1 want 0"); end
    total++;
    if (got_q.size() != 512) begin
      bad++; $display("FAIL end_len: got %0d want 512", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL end_ent%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (got_q.size() == 0 || got_q[got_q.size() - 1].pc !== 9'd511 ||
        got_q[got_q.size() - 1].vc !== 32'h1) begin
      bad++; $display("FAIL end_last: got %h want pc 511 valC 1",
        got_q.size() > 0 ? got_q[got_q.size() - 1] : '0);
    end
    total++;
    if ({halted, illegal} !== 2'b10) begin
      bad++; $display("FAIL end_flags: got %b want 10", {halted, illegal});
    end
    total++;
    if (post_end != 0) begin
      bad++; $display("FAIL end_wrap: got %0d issues after 511 want 0", post_end);
    end
  endtask

  initial begin
    reset = 1'b1;
    working = 1'b0;
    dec_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_working_toggle();
    test_addr_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
